// File: rtl/main_memory_responder_pkg.sv
// main_memory_config: shared types and sizes for the main-memory responder.
// MAIN_MEMORY_INIT_PATTERN_EN selects the per-block reset fill pattern.
package main_memory_config;
  localparam int MAIN_MEMORY_BLOCK_SIZE = 4;
  localparam int MAIN_MEMORY_NUM_BLOCKS = 8;
  localparam int MAIN_MEMORY_ADDRESS_WIDTH = 32;
  localparam int MAIN_MEMORY_DATA_WIDTH = 128;
  localparam int MAIN_MEMORY_ACCESS_LATENCY = 4;
  typedef logic [MAIN_MEMORY_BLOCK_SIZE*8-1:0] mm_block_t;
  typedef logic [$clog2(MAIN_MEMORY_NUM_BLOCKS)-1:0] mm_index_t;
  typedef enum logic [1:0] {MM_IDLE, MM_BUSY, MM_RESP} mm_state_e;
  function automatic mm_block_t mm_init_block(input int i);
`ifdef MAIN_MEMORY_INIT_PATTERN_EN
    return {MAIN_MEMORY_BLOCK_SIZE{8'(i)}};
`else
    return '0;
`endif
  endfunction
endpackage

// File: rtl/main_memory_array.sv
// main_memory_array: block storage with one write port and a combinational read port.
// Reset contents come from mm_init_block (MAIN_MEMORY_INIT_PATTERN_EN aware).
module main_memory_array
  import main_memory_config::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      we,
  input  mm_index_t waddr,
  input  mm_block_t wdata,
  input  mm_index_t raddr,
  output mm_block_t rdata
);
  mm_block_t mem [MAIN_MEMORY_NUM_BLOCKS];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      for (int i = 0; i < MAIN_MEMORY_NUM_BLOCKS; i++) mem[i] <= mm_init_block(i);
    else if (we)
      mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/main_memory_responder.sv
// main_memory_responder: fixed-latency block read/write responder backing the cache hierarchy.
// Reset contents depend on MAIN_MEMORY_INIT_PATTERN_EN (see main_memory_array).
module main_memory_responder
  import main_memory_config::*;
#(
  parameter int ACCESS_LATENCY = MAIN_MEMORY_ACCESS_LATENCY,
  parameter int BLOCK_SIZE = MAIN_MEMORY_BLOCK_SIZE,
  parameter int NUM_BLOCKS = MAIN_MEMORY_NUM_BLOCKS,
  parameter int ADDR_WIDTH = MAIN_MEMORY_ADDRESS_WIDTH,
  parameter int DATA_WIDTH = MAIN_MEMORY_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error
);
  localparam int BW = BLOCK_SIZE * 8;
  localparam logic [3:0] LOAD = 4'(ACCESS_LATENCY - 1);
  localparam bit DIRECT = ACCESS_LATENCY == 1;
  mm_state_e state, state_n;
  logic [3:0] cnt, cnt_n;
  logic lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr, acc_addr;
  mm_block_t lat_wdata, acc_wdata, rd_block;
  mm_index_t acc_index;
  logic accept, from_req, acc_write, acc_go, oor, mem_we;
  logic unused_wdata_bits;
  assign unused_wdata_bits = ^req_wdata[DATA_WIDTH-1:BW];
  // With a one-cycle latency the access happens on the accept edge straight from the request.
  always_comb begin
    accept = state == MM_IDLE && req_valid;
    from_req = state == MM_IDLE;
    acc_write = from_req ? req_write : lat_write;
    acc_addr = from_req ? req_addr : lat_addr;
    acc_wdata = from_req ? req_wdata[BW-1:0] : lat_wdata;
    acc_index = mm_index_t'(acc_addr / ADDR_WIDTH'(BLOCK_SIZE));
    oor = acc_addr >= ADDR_WIDTH'(BLOCK_SIZE * NUM_BLOCKS);
    acc_go = (state == MM_BUSY && cnt == 4'd0) || (DIRECT && accept);
    mem_we = acc_go && acc_write && !oor;
    state_n = accept ? (DIRECT ? MM_RESP : MM_BUSY)
            : acc_go ? MM_RESP
            : (state == MM_RESP && resp_ready) ? MM_IDLE : state;
    cnt_n = accept ? LOAD : (state == MM_BUSY && cnt != 4'd0) ? cnt - 4'd1 : cnt;
    req_ready = state == MM_IDLE;
    resp_valid = state == MM_RESP;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MM_IDLE;
      cnt <= '0;
      lat_write <= 1'b0;
      lat_addr <= '0;
      lat_wdata <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) begin
        lat_write <= req_write;
        lat_addr <= req_addr;
        lat_wdata <= req_wdata[BW-1:0];
      end
      if (acc_go) begin
        resp_error <= oor;
        resp_rdata <= (acc_write || oor) ? '0 : DATA_WIDTH'(rd_block);
      end
    end
  end
  main_memory_array u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (acc_index),
    .wdata (acc_wdata),
    .raddr (acc_index),
    .rdata (rd_block)
  );
endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder: directed checks of the responder at latency 4 and latency 1.
module tb_main_memory_responder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_error;
  logic [127:0] resp_rdata;
  logic v1 = 1'b0, w1 = 1'b0, rr1 = 1'b0;
  logic [31:0] a1 = '0;
  logic [127:0] d1 = '0;
  logic rdy1, rv1, err1;
  logic [127:0] rd1;
  int vectors = 0, errors = 0;

  always #5 clk = ~clk;

  main_memory_responder dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_error(resp_error)
  );

  main_memory_responder #(.ACCESS_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1),
    .req_write(w1), .req_addr(a1), .req_wdata(d1),
    .resp_valid(rv1), .resp_ready(rr1), .resp_rdata(rd1), .resp_error(err1)
  );

  function automatic logic [127:0] init_blk(input int i);
`ifdef MAIN_MEMORY_INIT_PATTERN_EN
    return {96'h0, {4{8'(i)}}};
`else
    return '0;
`endif
  endfunction

  // Presents one request on the latency-4 instance and counts edges until resp_valid.
  task automatic issue(input logic w, input logic [31:0] a, input logic [127:0] d, output int lat);
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    vectors++; if (resp_rdata !== 128'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    vectors++; if (resp_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", resp_error); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    int lat;
    resp_ready = 1'b1;
    issue(1'b0, 32'h08, '0, lat);
    vectors++; if (lat !== 4) begin errors++; $display("FAIL read_latency got %0d want 4", lat); end
    vectors++; if (resp_rdata !== init_blk(2)) begin errors++; $display("FAIL read_08_rdata got %h want %h", resp_rdata, init_blk(2)); end
    vectors++; if (resp_error !== 1'b0) begin errors++; $display("FAIL read_08_error got %b want 0", resp_error); end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    vectors++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL read_handshake got valid=%b ready=%b want 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_write_read();
    int lat;
    issue(1'b1, 32'h0C, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hDEADBEEF}, lat);
    vectors++; if (resp_rdata !== 128'h0 || resp_error !== 1'b0) begin errors++; $display("FAIL write_0c_resp got rdata=%h err=%b want 0/0", resp_rdata, resp_error); end
    finish_resp();
    issue(1'b0, 32'h0E, '0, lat);
    vectors++; if (resp_rdata !== 128'hDEADBEEF) begin errors++; $display("FAIL read_0e_rdata got %h want %h", resp_rdata, 128'hDEADBEEF); end
    finish_resp();
    issue(1'b0, 32'h1C, '0, lat);
    vectors++; if (resp_rdata !== init_blk(7) || resp_error !== 1'b0) begin errors++; $display("FAIL read_1c_last got rdata=%h err=%b want %h/0", resp_rdata, resp_error, init_blk(7)); end
    finish_resp();
  endtask

  task automatic test_out_of_range();
    int lat;
    issue(1'b0, 32'h20, '0, lat);
    vectors++; if (resp_error !== 1'b1 || resp_rdata !== 128'h0) begin errors++; $display("FAIL read_20_oor got err=%b rdata=%h want 1/0", resp_error, resp_rdata); end
    finish_resp();
    issue(1'b1, 32'h40, 128'h12345678, lat);
    vectors++; if (resp_error !== 1'b1 || resp_rdata !== 128'h0) begin errors++; $display("FAIL write_40_oor got err=%b rdata=%h want 1/0", resp_error, resp_rdata); end
    finish_resp();
    issue(1'b0, 32'h8000_0000, '0, lat);
    vectors++; if (resp_error !== 1'b1) begin errors++; $display("FAIL read_high_oor got err=%b want 1", resp_error); end
    finish_resp();
    issue(1'b0, 32'h00, '0, lat);
    vectors++; if (resp_rdata !== init_blk(0) || resp_error !== 1'b0) begin errors++; $display("FAIL read_00_unchanged got rdata=%h err=%b want %h/0", resp_rdata, resp_error, init_blk(0)); end
    finish_resp();
  endtask

  task automatic test_stall();
    int lat;
    issue(1'b0, 32'h0C, '0, lat);
    req_write = 1'b1; req_addr = 32'h00; req_wdata = 128'h55; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      vectors++; if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== 128'hDEADBEEF) begin errors++; $display("FAIL stall_%0d got valid=%b ready=%b rdata=%h want 1/0/deadbeef", k, resp_valid, req_ready, resp_rdata); end
    end
    req_valid = 1'b0;
    finish_resp();
    issue(1'b0, 32'h00, '0, lat);
    vectors++; if (resp_rdata !== init_blk(0)) begin errors++; $display("FAIL stall_ignored_write got %h want %h", resp_rdata, init_blk(0)); end
    finish_resp();
  endtask

  task automatic test_reset_mid();
    int lat;
    req_write = 1'b1; req_addr = 32'h1C; req_wdata = 128'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 128'h0 || resp_error !== 1'b0) begin errors++; $display("FAIL midreset_outputs got ready=%b valid=%b rdata=%h err=%b want 1/0/0/0", req_ready, resp_valid, resp_rdata, resp_error); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 32'h1C, '0, lat);
    vectors++; if (resp_rdata !== init_blk(7)) begin errors++; $display("FAIL midreset_discard got %h want %h", resp_rdata, init_blk(7)); end
    finish_resp();
  endtask

  task automatic test_latency1();
    rr1 = 1'b1; w1 = 1'b0; a1 = 32'h04; v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    vectors++; if (rv1 !== 1'b1 || rd1 !== init_blk(1) || err1 !== 1'b0) begin errors++; $display("FAIL lat1_read got valid=%b rdata=%h err=%b want 1/%h/0", rv1, rd1, err1, init_blk(1)); end
    @(posedge clk); #1;
    w1 = 1'b1; a1 = 32'h10; d1 = 128'hA5A5A5A5; v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    vectors++; if (rv1 !== 1'b1 || rd1 !== 128'h0 || err1 !== 1'b0) begin errors++; $display("FAIL lat1_write got valid=%b rdata=%h err=%b want 1/0/0", rv1, rd1, err1); end
    @(posedge clk); #1;
    w1 = 1'b0; a1 = 32'h10;
  endtask

  task automatic test_back_to_back();
    v1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k % 2 == 0) begin
        vectors++; if (rv1 !== 1'b1 || rdy1 !== 1'b0 || rd1 !== 128'hA5A5A5A5) begin errors++; $display("FAIL b2b_resp_%0d got valid=%b ready=%b rdata=%h want 1/0/a5a5a5a5", k, rv1, rdy1, rd1); end
      end else begin
        vectors++; if (rv1 !== 1'b0 || rdy1 !== 1'b1) begin errors++; $display("FAIL b2b_idle_%0d got valid=%b ready=%b want 0/1", k, rv1, rdy1); end
      end
    end
    v1 = 1'b0;
    rr1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_out_of_range();
    test_stall();
    test_reset_mid();
    test_latency1();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
